// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register built as a 2-entry skid buffer; also resolves beq/bne at push time.
// Latency: 1 cycle from push into an empty stage to the entry on mem_*; branch pulse 1 cycle after push.
// Backpressure: ex_ready_o drops only when both entries are held; it is a function of state alone (no mem_ready_i path).
//
// Ports:
//   clk_i, rst_n                 clock (rising edge), async active-low reset
//   flush_i                      squash buffered entries and any same-cycle push
//   ex_valid_i / ex_ready_o      upstream handshake; alu_result_i, alu_zero_i, rt_data_i, rd_addr_i,
//                                reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, branch_*_i are the payload
//   mem_valid_o / mem_ready_i    downstream handshake; mem_result_o, mem_wdata_o, mem_rd_o, mem_ctrl_o carry the head
//   branch_taken_o, branch_target_o   one-cycle taken-branch pulse and its target
//   occupancy_o                  entries held (0..2)
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              branch_i,
    input  logic              branch_ne_i,
    input  logic [DATA_W-1:0] branch_target_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] mem_result_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic [3:0]        mem_ctrl_o,
    output logic              branch_taken_o,
    output logic [DATA_W-1:0] branch_target_o,
    output logic [1:0]        occupancy_o
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] wdata;
        logic [REG_AW-1:0] rd;
        logic [3:0]        ctrl;   // {reg_write, mem_to_reg, mem_read, mem_write}
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    entry_t            head;
    entry_t            skid;
    entry_t            in_ent;
    logic              push;
    logic              pop;
    logic              taken;
    logic              taken_q;
    logic [DATA_W-1:0] target_q;
    logic [1:0]        occ_q;

    assign in_ent = '{result: alu_result_i,
                      wdata:  rt_data_i,
                      rd:     rd_addr_i,
                      ctrl:   {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i}};

    // rst_n term keeps ready low for the whole reset window, not just after the first edge.
    assign ex_ready_o  = rst_n & (state != FULL);
    assign mem_valid_o = (state != EMPTY);
    assign push        = ex_valid_i & ex_ready_o;
    assign pop         = mem_valid_o & mem_ready_i;
    assign taken       = branch_i & (alu_zero_i ^ branch_ne_i);

    // Head payload is blanked whenever nothing is valid.
    assign mem_result_o    = mem_valid_o ? head.result : '0;
    assign mem_wdata_o     = mem_valid_o ? head.wdata  : '0;
    assign mem_rd_o        = mem_valid_o ? head.rd     : '0;
    assign mem_ctrl_o      = mem_valid_o ? head.ctrl   : '0;
    assign branch_taken_o  = taken_q;
    assign branch_target_o = target_q;
    assign occupancy_o     = occ_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            head     <= '0;
            skid     <= '0;
            occ_q    <= 2'd0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            // Branch pulse does not care which slot the entry lands in; a flush kills it.
            taken_q  <= push & taken & ~flush_i;
            target_q <= (push & taken & ~flush_i) ? branch_target_i : '0;

            if (flush_i) begin
                // A same-cycle pop has already been taken by MEM; a same-cycle push is dropped.
                state <= EMPTY;
                occ_q <= 2'd0;
                head  <= '0;
                skid  <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (push) begin
                            head  <= in_ent;
                            state <= ONE;
                            occ_q <= 2'd1;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head <= in_ent;
                        end else if (push) begin
                            skid  <= in_ent;
                            state <= FULL;
                            occ_q <= 2'd2;
                        end else if (pop) begin
                            head  <= '0;
                            state <= EMPTY;
                            occ_q <= 2'd0;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            head  <= skid;
                            skid  <= '0;
                            state <= ONE;
                            occ_q <= 2'd1;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                        occ_q <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic [31:0] rt_data_i;
    logic [4:0]  rd_addr_i;
    logic        reg_write_i;
    logic        mem_to_reg_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        branch_i;
    logic        branch_ne_i;
    logic [31:0] branch_target_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_result_o;
    logic [31:0] mem_wdata_o;
    logic [4:0]  mem_rd_o;
    logic [3:0]  mem_ctrl_o;
    logic        branch_taken_o;
    logic [31:0] branch_target_o;
    logic [1:0]  occupancy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ex_mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .alu_result_i    (alu_result_i),
        .alu_zero_i      (alu_zero_i),
        .rt_data_i       (rt_data_i),
        .rd_addr_i       (rd_addr_i),
        .reg_write_i     (reg_write_i),
        .mem_to_reg_i    (mem_to_reg_i),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .branch_i        (branch_i),
        .branch_ne_i     (branch_ne_i),
        .branch_target_i (branch_target_i),
        .mem_valid_o     (mem_valid_o),
        .mem_ready_i     (mem_ready_i),
        .mem_result_o    (mem_result_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rd_o        (mem_rd_o),
        .mem_ctrl_o      (mem_ctrl_o),
        .branch_taken_o  (branch_taken_o),
        .branch_target_o (branch_target_o),
        .occupancy_o     (occupancy_o)
    );

    // Advance one clock; inputs and samples sit 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] res, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [3:0] ctrl, input logic br,
                         input logic bne, input logic zero, input logic [31:0] tgt);
        ex_valid_i      = vld;
        alu_result_i    = res;
        rt_data_i       = wd;
        rd_addr_i       = rd;
        {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i} = ctrl;
        branch_i        = br;
        branch_ne_i     = bne;
        alu_zero_i      = zero;
        branch_target_i = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush_i = 1'b0;
        mem_ready_i = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 4'b1111, 1'b1, 1'b1, 1'b0, 32'hCAFE_0000);
        #3;
        tick();
        checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", ex_ready_o); end
        checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", mem_valid_o); end
        checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy_o); end
        checks++; if (branch_taken_o !== 1'b0 || branch_target_o !== 32'h0) begin errors++; $display("FAIL reset_branch got=%0b/%h exp=0/0", branch_taken_o, branch_target_o); end
        checks++; if (mem_result_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_rd_o !== 5'd0 || mem_ctrl_o !== 4'h0) begin
            errors++; $display("FAIL reset_data got=%h/%h/%0d/%b exp=0", mem_result_o, mem_wdata_o, mem_rd_o, mem_ctrl_o); end
        idle();
        rst_n = 1'b1;
        tick();
        checks++; if (ex_ready_o !== 1'b1 || occupancy_o !== 2'd0 || mem_valid_o !== 1'b0) begin
            errors++; $display("FAIL post_reset got rdy=%0b occ=%0d vld=%0b exp 1/0/0", ex_ready_o, occupancy_o, mem_valid_o); end
    endtask

    task automatic test_single();
        mem_ready_i = 1'b1;
        drive(1'b1, 32'h0000_00A5, 32'hDEAD_BEEF, 5'd5, 4'b1000, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        checks++; if (mem_valid_o !== 1'b1 || mem_result_o !== 32'hA5 || mem_rd_o !== 5'd5) begin
            errors++; $display("FAIL single_head got vld=%0b res=%h rd=%0d exp 1/a5/5", mem_valid_o, mem_result_o, mem_rd_o); end
        checks++; if (mem_wdata_o !== 32'hDEAD_BEEF || mem_ctrl_o !== 4'b1000 || occupancy_o !== 2'd1) begin
            errors++; $display("FAIL single_payload got wd=%h ctrl=%b occ=%0d exp deadbeef/1000/1", mem_wdata_o, mem_ctrl_o, occupancy_o); end
        tick();
        checks++; if (mem_valid_o !== 1'b0 || mem_result_o !== 32'h0 || occupancy_o !== 2'd0) begin
            errors++; $display("FAIL single_drain got vld=%0b res=%h occ=%0d exp 0/0/0", mem_valid_o, mem_result_o, occupancy_o); end
    endtask

    task automatic test_skid();
        mem_ready_i = 1'b0;
        drive(1'b1, 32'h11, 32'h0, 5'd1, 4'b1010, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h22, 32'h0, 5'd2, 4'b0001, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        checks++; if (occupancy_o !== 2'd2 || ex_ready_o !== 1'b0 || mem_result_o !== 32'h11) begin
            errors++; $display("FAIL skid_full got occ=%0d rdy=%0b res=%h exp 2/0/11", occupancy_o, ex_ready_o, mem_result_o); end
        mem_ready_i = 1'b1;
        tick();
        checks++; if (mem_result_o !== 32'h22 || mem_rd_o !== 5'd2 || mem_ctrl_o !== 4'b0001 || ex_ready_o !== 1'b1 || occupancy_o !== 2'd1) begin
            errors++; $display("FAIL skid_second got res=%h rd=%0d ctrl=%b rdy=%0b occ=%0d exp 22/2/0001/1/1", mem_result_o, mem_rd_o, mem_ctrl_o, ex_ready_o, occupancy_o); end
        tick();
        checks++; if (mem_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            errors++; $display("FAIL skid_drain got vld=%0b occ=%0d exp 0/0", mem_valid_o, occupancy_o); end
    endtask

    task automatic test_simul();
        mem_ready_i = 1'b0;
        drive(1'b1, 32'h44, 32'h0, 5'd4, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        mem_ready_i = 1'b1;
        drive(1'b1, 32'h33, 32'h0, 5'd3, 4'b0100, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        mem_ready_i = 1'b0;
        checks++; if (occupancy_o !== 2'd1 || mem_result_o !== 32'h33 || mem_rd_o !== 5'd3) begin
            errors++; $display("FAIL simul_pushpop got occ=%0d res=%h rd=%0d exp 1/33/3", occupancy_o, mem_result_o, mem_rd_o); end
        mem_ready_i = 1'b1;
        tick();
        checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL simul_drain got occ=%0d exp 0", occupancy_o); end
    endtask

    task automatic test_branch();
        mem_ready_i = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0040_0020);
        tick();
        idle();
        checks++; if (branch_taken_o !== 1'b1 || branch_target_o !== 32'h0040_0020) begin
            errors++; $display("FAIL bne_taken got %0b/%h exp 1/00400020", branch_taken_o, branch_target_o); end
        tick();
        checks++; if (branch_taken_o !== 1'b0 || branch_target_o !== 32'h0) begin
            errors++; $display("FAIL bne_one_cycle got %0b/%h exp 0/0", branch_taken_o, branch_target_o); end
        drive(1'b1, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0040_0040);
        tick();
        idle();
        checks++; if (branch_taken_o !== 1'b0 || branch_target_o !== 32'h0) begin
            errors++; $display("FAIL beq_not_taken got %0b/%h exp 0/0", branch_taken_o, branch_target_o); end
        drive(1'b1, 32'h0, 32'h0, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0000_1000);
        tick();
        idle();
        checks++; if (branch_taken_o !== 1'b1 || branch_target_o !== 32'h0000_1000) begin
            errors++; $display("FAIL beq_taken got %0b/%h exp 1/00001000", branch_taken_o, branch_target_o); end
        tick();
        // Taken branch landing in the skid slot still pulses.
        mem_ready_i = 1'b0;
        drive(1'b1, 32'h5, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h6, 32'h0, 5'd0, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0000_2000);
        tick();
        idle();
        checks++; if (branch_taken_o !== 1'b1 || branch_target_o !== 32'h0000_2000 || occupancy_o !== 2'd2) begin
            errors++; $display("FAIL skid_branch got %0b/%h occ=%0d exp 1/00002000/2", branch_taken_o, branch_target_o, occupancy_o); end
        mem_ready_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_flush_reset();
        mem_ready_i = 1'b0;
        drive(1'b1, 32'h55, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h66, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 32'h77, 32'h0, 5'd7, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0000_3000);
        tick();
        flush_i = 1'b0;
        idle();
        checks++; if (occupancy_o !== 2'd0 || mem_valid_o !== 1'b0 || branch_taken_o !== 1'b0) begin
            errors++; $display("FAIL flush_full got occ=%0d vld=%0b tkn=%0b exp 0/0/0", occupancy_o, mem_valid_o, branch_taken_o); end
        // Flush in ONE with an accepted taken-branch push: push is discarded and no pulse.
        drive(1'b1, 32'h78, 32'h0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 32'h79, 32'h0, 5'd9, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0000_4000);
        tick();
        flush_i = 1'b0;
        idle();
        checks++; if (occupancy_o !== 2'd0 || mem_valid_o !== 1'b0 || branch_taken_o !== 1'b0 || branch_target_o !== 32'h0) begin
            errors++; $display("FAIL flush_push got occ=%0d vld=%0b tkn=%0b tgt=%h exp 0/0/0/0", occupancy_o, mem_valid_o, branch_taken_o, branch_target_o); end
        drive(1'b1, 32'h88, 32'h0, 5'd8, 4'b1100, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        checks++; if (occupancy_o !== 2'd1 || mem_result_o !== 32'h88) begin
            errors++; $display("FAIL pre_arst got occ=%0d res=%h exp 1/88", occupancy_o, mem_result_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_valid_o !== 1'b0 || mem_result_o !== 32'h0 || occupancy_o !== 2'd0 || ex_ready_o !== 1'b0) begin
            errors++; $display("FAIL async_reset got vld=%0b res=%h occ=%0d rdy=%0b exp 0/0/0/0", mem_valid_o, mem_result_o, occupancy_o, ex_ready_o); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (ex_ready_o !== 1'b1 || occupancy_o !== 2'd0 || branch_taken_o !== 1'b0) begin
            errors++; $display("FAIL after_arst got rdy=%0b occ=%0d tkn=%0b exp 1/0/0", ex_ready_o, occupancy_o, branch_taken_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_simul();
        test_branch();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
